// File: rtl/id_ex_stage_if.sv
// ID-to-EX handshake bundle: decoded fields forward,
// load-use stall request back toward PC and IF/ID.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [2:0]        id_alu_control;
  logic              id_alu_src;
  logic              id_reg_dst;
  logic              id_reg_write;
  logic              id_mem_to_reg;
  logic              id_mem_write;
  logic              stall_o;

  modport master (
    output id_valid, id_rd1, id_rd2, id_imm,
    output id_rs, id_rt, id_rd,
    output id_alu_control, id_alu_src, id_reg_dst,
    output id_reg_write, id_mem_to_reg, id_mem_write,
    input  stall_o
  );

  modport slave (
    input  id_valid, id_rd1, id_rd2, id_imm,
    input  id_rs, id_rt, id_rd,
    input  id_alu_control, id_alu_src, id_reg_dst,
    input  id_reg_write, id_mem_to_reg, id_mem_write,
    output stall_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding,
// load-use bubble insertion, downstream hold and flush.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              hold_i,
  id_ex_stage_if.slave      id,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_write_reg,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] SrcA,
  output logic [DATA_W-1:0] SrcB,
  output logic [2:0]        ALUControl,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_write_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_write
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] wr;
    logic [2:0]        alu;
    logic              alu_src;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
  } ex_t;

  ex_t ex_q;
  ex_t ex_cap;

  logic              hazard;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  // Load in EX feeding a source of the ID instruction.
  always_comb begin
    hazard = ex_q.valid & ex_q.mem_to_reg
           & (ex_q.wr != '0) & id.id_valid
           & ((ex_q.wr == id.id_rs)
             | (ex_q.wr == id.id_rt));
  end

  assign id.stall_o = hazard & ~hold_i;

  // Assemble the EX bundle captured from ID.
  always_comb begin
    ex_cap            = '0;
    ex_cap.valid      = id.id_valid;
    ex_cap.rd1        = id.id_rd1;
    ex_cap.rd2        = id.id_rd2;
    ex_cap.imm        = id.id_imm;
    ex_cap.rs         = id.id_rs;
    ex_cap.rt         = id.id_rt;
    ex_cap.wr         = id.id_reg_dst ? id.id_rd
                                      : id.id_rt;
    ex_cap.alu        = id.id_alu_control;
    ex_cap.alu_src    = id.id_alu_src;
    ex_cap.reg_write  = id.id_reg_write & id.id_valid;
    ex_cap.mem_to_reg = id.id_mem_to_reg & id.id_valid;
    ex_cap.mem_write  = id.id_mem_write & id.id_valid;
  end

  // EX register: flush, then hold, then bubble, then capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (flush_i) begin
      ex_q <= '0;
    end else if (hold_i) begin
      ex_q <= ex_q;
    end else if (hazard) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_cap;
    end
  end

  // Forwarding muxes: EX/MEM beats MEM/WB, $0 never forwarded.
  always_comb begin
    fwd_a = ex_q.rd1;
    fwd_b = ex_q.rd2;
    if (mem_reg_write && mem_write_reg != '0
        && mem_write_reg == ex_q.rs) begin
      fwd_a = mem_alu_result;
    end else if (wb_reg_write && wb_write_reg != '0
                 && wb_write_reg == ex_q.rs) begin
      fwd_a = wb_result;
    end
    if (mem_reg_write && mem_write_reg != '0
        && mem_write_reg == ex_q.rt) begin
      fwd_b = mem_alu_result;
    end else if (wb_reg_write && wb_write_reg != '0
                 && wb_write_reg == ex_q.rt) begin
      fwd_b = wb_result;
    end
  end

  assign SrcA          = fwd_a;
  assign SrcB          = ex_q.alu_src ? ex_q.imm : fwd_b;
  assign ex_store_data = fwd_b;
  assign ALUControl    = ex_q.alu;
  assign ex_valid      = ex_q.valid;
  assign ex_write_reg  = ex_q.wr;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_mem_write  = ex_q.mem_write;

endmodule
